apb_slave_regbank: RTL

//  APB completer (responder) end of the APB-bridge link: decodes APB transfers and serves a bank of
//  NUM_REGS 32-bit control registers. Register 0 is a read-only status word from the core.

---
 rtl/apb_pkg.sv | 31 +++
 rtl/apb_slave_regbank.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared APB definitions for the completer register bank and the APB master.
//   apb_slv_state_t : completer FSM states (IDLE, WAIT, RESP)
//   APB_ADDR_LSB    : number of byte-offset bits below a 32-bit word index
//   apb_is_aligned  : true when the byte-offset bits of an address are zero
//   apb_in_window   : true when an address falls inside [base, base+size)
// -----------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_slv_state_t;

    localparam int APB_ADDR_LSB = 2;

    function automatic logic apb_is_aligned(input logic [APB_ADDR_LSB-1:0] i_lsbs);
        return (i_lsbs == '0);
    endfunction

    // Operands are widened to 64 bits so neither the subtraction nor the
    // compare can wrap for any supported address width.
    function automatic logic apb_in_window(input logic [63:0] i_addr,
                                           input logic [63:0] i_base,
                                           input logic [63:0] i_size);
        return (i_addr >= i_base) && ((i_addr - i_base) < i_size);
    endfunction

endpackage : apb_pkg

// File: rtl/apb_slave_regbank.sv
// -----------------------------------------------------------------------------
// apb_slave_regbank
// APB completer serving NUM_REGS 32-bit control registers. Register 0 is a
// read-only status word driven by the core; the rest are read/write.
// A fixed number of wait states is inserted on every transfer and PSLVERR is
// raised for misaligned, out-of-window or read-only-write accesses.
//
// Ports
//   i_clk_apb   APB clock
//   i_rstn_apb  asynchronous active-low reset
//   i_psel      peripheral select
//   i_penable   access-phase enable
//   i_pwrite    1 = write, 0 = read
//   i_paddr     byte address
//   i_pwdata    write data
//   o_prdata    read data (meaningful only with o_pready on a read)
//   o_pready    transfer completion, one cycle
//   o_pslverr   error flag (meaningful only with o_pready)
//   i_status    value returned for reads of register 0
//   o_regs      flattened register contents, slice 0 tied to zero
//   o_wr_pulse  one-cycle strobe per register when its new value is visible
// -----------------------------------------------------------------------------
module apb_slave_regbank
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h4000_0000,
    parameter int                    WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                           i_clk_apb,
    input  logic                           i_rstn_apb,
    input  logic                           i_psel,
    input  logic                           i_penable,
    input  logic                           i_pwrite,
    input  logic [ADDR_WIDTH-1:0]          i_paddr,
    input  logic [DATA_WIDTH-1:0]          i_pwdata,
    output logic [DATA_WIDTH-1:0]          o_prdata,
    output logic                           o_pready,
    output logic                           o_pslverr,
    input  logic [DATA_WIDTH-1:0]          i_status,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs,
    output logic [NUM_REGS-1:0]            o_wr_pulse
);

    localparam int          IDX_W    = $clog2(NUM_REGS);
    localparam logic [3:0]  WS_LOAD  = 4'(WAIT_STATES);
    localparam logic [63:0] WIN_BASE = 64'(BASE_ADDR);
    localparam logic [63:0] WIN_SIZE = 64'(NUM_REGS * (1 << APB_ADDR_LSB));

    // FSM and latched transfer
    apb_slv_state_t        r_state;
    apb_slv_state_t        w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_err;

    // Registered APB response
    logic                  r_pready;
    logic                  r_pslverr;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic [NUM_REGS-1:0]   r_wr_pulse;

    // Decode and response datapath
    logic                  w_setup;
    logic                  w_access;
    logic [IDX_W-1:0]      w_setup_idx;
    logic                  w_setup_err;
    logic                  w_cur_write;
    logic                  w_cur_err;
    logic [IDX_W-1:0]      w_cur_idx;
    logic                  w_resp_nxt;
    logic [DATA_WIDTH-1:0] w_prdata_nxt;
    logic                  w_commit;
    logic [NUM_REGS-1:0]   w_pulse_nxt;
    logic [DATA_WIDTH-1:0] w_reg_arr [NUM_REGS];

    assign w_setup  = i_psel & ~i_penable;
    assign w_access = i_psel &  i_penable;

    // Only the index bits of the offset are kept; the full-width range check
    // lives in apb_in_window.
    assign w_setup_idx = IDX_W'((i_paddr - BASE_ADDR) >> APB_ADDR_LSB);
    assign w_setup_err = !apb_is_aligned(i_paddr[APB_ADDR_LSB-1:0])
                       || !apb_in_window(64'(i_paddr), WIN_BASE, WIN_SIZE)
                       || (i_pwrite && (w_setup_idx == '0));

    // With zero wait states RESP is entered straight from IDLE, before the
    // transfer has been latched, so the response uses the live decode there.
    assign w_cur_write = (r_state == IDLE) ? i_pwrite    : r_write;
    assign w_cur_err   = (r_state == IDLE) ? w_setup_err : r_err;
    assign w_cur_idx   = (r_state == IDLE) ? w_setup_idx : r_idx;

    // Commit requires the master to still be in the access phase at the end
    // of RESP; a dropped PSEL there is an abort.
    assign w_commit = (r_state == RESP) & w_access & r_write & ~r_err;

    // NOTE: every variable assigned in an always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_setup) begin
                    w_cnt_nxt   = WS_LOAD;
                    w_state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!i_psel) begin
                    w_state_nxt = IDLE;
                end else if (i_penable) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_state_nxt = RESP;
                    end
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_resp_nxt   = (w_state_nxt == RESP);
        w_prdata_nxt = '0;
        if (w_resp_nxt && !w_cur_write && !w_cur_err) begin
            w_prdata_nxt = (w_cur_idx == '0) ? i_status : w_reg_arr[w_cur_idx];
        end
    end

    always_comb begin
        w_pulse_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_pulse_nxt[i] = w_commit && (r_idx == IDX_W'(i));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
        if (!i_rstn_apb) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
        if (!i_rstn_apb) begin
            r_write <= 1'b0;
            r_wdata <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else if ((r_state == IDLE) && w_setup) begin
            r_write <= i_pwrite;
            r_wdata <= i_pwdata;
            r_idx   <= w_setup_idx;
            r_err   <= w_setup_err;
        end
    end

    always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
        if (!i_rstn_apb) begin
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
            r_prdata   <= '0;
            r_wr_pulse <= '0;
        end else begin
            r_pready   <= w_resp_nxt;
            r_pslverr  <= w_resp_nxt & w_cur_err;
            r_prdata   <= w_prdata_nxt;
            r_wr_pulse <= w_pulse_nxt;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (g == 0) begin : g_status
            assign w_reg_arr[g] = '0;
        end else begin : g_rw
            logic [DATA_WIDTH-1:0] r_reg;
            // NOTE: the bank is reset explicitly because software relies on
            // RESET_VAL after reset; this is flop storage, not a RAM macro.
            always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
                if (!i_rstn_apb) begin
                    r_reg <= RESET_VAL;
                end else if (w_pulse_nxt[g]) begin
                    r_reg <= r_wdata;
                end
            end
            assign w_reg_arr[g] = r_reg;
        end
        assign o_regs[g*DATA_WIDTH +: DATA_WIDTH] = w_reg_arr[g];
    end

    assign o_prdata   = r_prdata;
    assign o_pready   = r_pready;
    assign o_pslverr  = r_pslverr;
    assign o_wr_pulse = r_wr_pulse;

endmodule : apb_slave_regbank
